// File: rtl/neander_uart_io_if.sv
// CPU-side I/O port bundle of the NEANDER-X UART peripheral.
// master = CPU (drives OUT data/strobe), slave = peripheral (returns IN data/status).
interface neander_uart_io_if;
  logic [7:0] io_out;
  logic       io_write;
  logic [7:0] io_in;
  logic [7:0] io_status;

  modport master (output io_out, output io_write, input io_in, input io_status);
  modport slave  (input io_out, input io_write, output io_in, output io_status);
endinterface

// File: rtl/neander_uart_io.sv
// NEANDER-X I/O peripheral: TX FIFO plus 8N1 UART transmitter, status/IN register.
// Optional receiver built when NEANDER_UART_RX_EN is defined.
module neander_uart_io #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  neander_uart_io_if.slave        bus,
  output logic                    uart_tx,
  input  logic                    uart_rx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  logic          fifo_full, fifo_empty, push, pop, shift_en;

  tx_state_t     tx_state_reg, tx_state_next;
  logic [TW-1:0] tx_timer_reg, tx_timer_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shift_reg;
  logic          tx_reg, tx_next;
  logic          tx_full_reg, tx_idle_reg, tx_ovf_reg;

  logic [7:0]    rx_byte_reg;
  logic [3:0]    rx_count_reg;
  logic          rx_ferr_reg;

  assign fifo_full  = (count_reg == DEPTH_C);
  assign fifo_empty = (count_reg == '0);
  // A pop in the same cycle frees a slot, so a write while full still lands.
  assign push       = bus.io_write && (!fifo_full || pop);

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_timer_next = tx_timer_reg;
    bit_idx_next  = bit_idx_reg;
    tx_next       = tx_reg;
    pop           = 1'b0;
    shift_en      = 1'b0;
    case (tx_state_reg)
      TX_IDLE: begin
        tx_next = 1'b1;
        if (!fifo_empty) begin
          pop           = 1'b1;
          tx_state_next = TX_START;
          tx_timer_next = BIT_LAST;
          tx_next       = 1'b0;
        end
      end
      TX_START: begin
        if (tx_timer_reg == '0) begin
          tx_state_next = TX_DATA;
          tx_timer_next = BIT_LAST;
          bit_idx_next  = 3'd0;
          tx_next       = shift_reg[0];
        end else begin
          tx_timer_next = tx_timer_reg - 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_timer_reg == '0) begin
          tx_timer_next = BIT_LAST;
          if (bit_idx_reg == 3'd7) begin
            tx_state_next = TX_STOP;
            tx_next       = 1'b1;
          end else begin
            bit_idx_next = bit_idx_reg + 1'b1;
            shift_en     = 1'b1;
            tx_next      = shift_reg[1];
          end
        end else begin
          tx_timer_next = tx_timer_reg - 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_timer_reg == '0) begin
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            pop           = 1'b1;
            tx_state_next = TX_START;
            tx_timer_next = BIT_LAST;
            tx_next       = 1'b0;
          end else begin
            tx_state_next = TX_IDLE;
            tx_next       = 1'b1;
          end
        end else begin
          tx_timer_next = tx_timer_reg - 1'b1;
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= bus.io_out;
  end

  always_ff @(posedge clk) begin
    if (pop)           shift_reg <= mem[rd_ptr_reg];
    else if (shift_en) shift_reg <= {1'b0, shift_reg[7:1]};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      tx_state_reg <= TX_IDLE;
      tx_timer_reg <= '0;
      bit_idx_reg  <= '0;
      tx_reg       <= 1'b1;
      tx_full_reg  <= 1'b0;
      tx_idle_reg  <= 1'b1;
      tx_ovf_reg   <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg    <= count_next;
      tx_state_reg <= tx_state_next;
      tx_timer_reg <= tx_timer_next;
      bit_idx_reg  <= bit_idx_next;
      tx_reg       <= tx_next;
      // Status flags track the post-edge state so they are stable all cycle.
      tx_full_reg  <= (count_next == DEPTH_C);
      tx_idle_reg  <= (count_next == '0) && (tx_state_next == TX_IDLE);
      tx_ovf_reg   <= tx_ovf_reg | (bus.io_write && !push);
    end
  end

`ifdef NEANDER_UART_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT/2 - 1);

  rx_state_t     rx_state_reg, rx_state_next;
  logic [TW-1:0] rx_timer_reg, rx_timer_next;
  logic [2:0]    rx_bit_reg, rx_bit_next;
  logic [7:0]    rx_shift_reg, rx_shift_next, rx_byte_next;
  logic [3:0]    rx_count_next;
  logic          rx_ferr_next;
  logic          rx_meta_reg, rx_sync_reg, rx_prev_reg;

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_timer_next = rx_timer_reg;
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    rx_byte_next  = rx_byte_reg;
    rx_count_next = rx_count_reg;
    rx_ferr_next  = rx_ferr_reg;
    case (rx_state_reg)
      RX_IDLE: begin
        if (rx_prev_reg && !rx_sync_reg) begin
          rx_state_next = RX_START;
          rx_timer_next = HALF_LAST;
        end
      end
      RX_START: begin
        if (rx_timer_reg == '0) begin
          // Line back high at mid-start-bit: treat as a glitch.
          if (rx_sync_reg) begin
            rx_state_next = RX_IDLE;
          end else begin
            rx_state_next = RX_DATA;
            rx_timer_next = BIT_LAST;
            rx_bit_next   = 3'd0;
          end
        end else begin
          rx_timer_next = rx_timer_reg - 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_timer_reg == '0) begin
          rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
          rx_timer_next = BIT_LAST;
          if (rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
          else                    rx_bit_next   = rx_bit_reg + 1'b1;
        end else begin
          rx_timer_next = rx_timer_reg - 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_timer_reg == '0) begin
          rx_state_next = RX_IDLE;
          if (rx_sync_reg) begin
            rx_byte_next  = rx_shift_reg;
            rx_count_next = rx_count_reg + 1'b1;
          end else begin
            rx_ferr_next = 1'b1;
          end
        end else begin
          rx_timer_next = rx_timer_reg - 1'b1;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta_reg  <= 1'b1;
      rx_sync_reg  <= 1'b1;
      rx_prev_reg  <= 1'b1;
      rx_state_reg <= RX_IDLE;
      rx_timer_reg <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_byte_reg  <= '0;
      rx_count_reg <= '0;
      rx_ferr_reg  <= 1'b0;
    end else begin
      rx_meta_reg  <= uart_rx;
      rx_sync_reg  <= rx_meta_reg;
      rx_prev_reg  <= rx_sync_reg;
      rx_state_reg <= rx_state_next;
      rx_timer_reg <= rx_timer_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
      rx_byte_reg  <= rx_byte_next;
      rx_count_reg <= rx_count_next;
      rx_ferr_reg  <= rx_ferr_next;
    end
  end
`else
  logic unused_rx;
  assign unused_rx    = uart_rx;
  assign rx_byte_reg  = 8'h00;
  assign rx_count_reg = 4'h0;
  assign rx_ferr_reg  = 1'b0;
`endif

  assign bus.io_in     = rx_byte_reg;
  assign bus.io_status = {rx_count_reg, rx_ferr_reg, tx_ovf_reg, tx_idle_reg, tx_full_reg};
  assign uart_tx       = tx_reg;

endmodule
